aes_decrypt_iter: RTL and testbench

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter.sv | 209 ++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter -- iterative AES decryptor (one round per clock), with
// optional CBC chaining.
//
// Parameters
//   NR   number of rounds: 10, 12 or 14 (AES-128/192/256)
//   CBC  0 = ECB, 1 = CBC decryption
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   in_valid/in_ready    ciphertext handshake (ready only when idle)
//   cipher_data          ciphertext block, byte 0 in [127:120]
//   iv_load, iv          load the chaining register (CBC only, idle only)
//   rk_idx/rk_data       round-key request; key store answers in-cycle
//   out_valid/out_ready  plaintext handshake
//   plain_data           decrypted block, held until accepted
//   busy                 high whenever the FSM is not idle
//
// Timing: accept edge loads state = C ^ rk[NR]; NR-1 full rounds follow,
// then one final round (no InvMixColumns), giving out_valid NR edges after
// the accept edge.
// ---------------------------------------------------------------------------
module aes_decrypt_iter #(
    parameter int NR  = 10,
    parameter int CBC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_data,
    input  logic         iv_load,
    input  logic [127:0] iv,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_data,
    output logic         busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_decrypt_iter: NR must be 10, 12 or 14");
    end

    localparam bit USE_CBC = (CBC != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (only 09/0b/0d/0e are used).
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^
               (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    // InvShiftRows followed by InvSubBytes. Byte i sits at row i%4, column
    // i/4; row r rotates right by r, so output (r,c) takes input (r,c-r).
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = INV_SBOX[s[127 - 8*(4*((c - r) & 3) + r) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {
                gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
        end
        return o;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] state_q, state_d;
    logic [127:0] c_hold_q, c_hold_d;
    logic [127:0] chain_q, chain_d;
    logic [127:0] plain_q, plain_d;
    logic         out_valid_q, out_valid_d;

    logic [127:0] sub_add;   // AddRoundKey(InvSubBytes(InvShiftRows(state)))
    logic [127:0] round_out;

    assign sub_add   = inv_shift_sub(state_q) ^ rk_data;
    assign round_out = inv_mix(sub_add);

    assign in_ready   = (fsm_q == S_IDLE);
    assign busy       = (fsm_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign plain_data = plain_q;

    always_comb begin
        case (fsm_q)
            S_IDLE:  rk_idx = 4'(NR);
            S_ROUND: rk_idx = r_q;
            default: rk_idx = 4'd0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // path through the case below can leave one unassigned (no latches).
        fsm_d       = fsm_q;
        r_d         = r_q;
        state_d     = state_q;
        c_hold_d    = c_hold_q;
        chain_d     = chain_q;
        plain_d     = plain_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            S_IDLE: begin
                // The IV is written on the same edge as an accept, so a
                // simultaneous load becomes this block's chaining value.
                if (USE_CBC && iv_load) chain_d = iv;
                if (in_valid) begin
                    state_d  = cipher_data ^ rk_data;
                    c_hold_d = cipher_data;
                    r_d      = 4'(NR - 1);
                    fsm_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = round_out;
                if (r_q == 4'd1) fsm_d = S_FINAL;
                else             r_d   = r_q - 4'd1;
            end
            S_FINAL: begin
                plain_d     = USE_CBC ? (sub_add ^ chain_q) : sub_add;
                if (USE_CBC) chain_d = c_hold_q;
                out_valid_d = 1'b1;
                fsm_d       = S_DONE;
            end
            default: begin   // S_DONE
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            r_q         <= 4'd0;
            state_q     <= '0;
            c_hold_q    <= '0;
            chain_q     <= '0;
            plain_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // values from before this edge, regardless of statement order.
            fsm_q       <= fsm_d;
            r_q         <= r_d;
            state_q     <= state_d;
            c_hold_q    <= c_hold_d;
            chain_q     <= chain_d;
            plain_q     <= plain_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_iter -- three instances: [0] AES-128 ECB, [1] AES-256 ECB,
// [2] AES-128 CBC. The bench expands each key into the round-key store that
// answers rk_idx combinationally. Expected plaintexts are pushed into a
// queue when a block is issued; a monitor pops and compares on every output
// handshake.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_iter;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CBC_IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CBC_C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CBC_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CBC_C2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CBC_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    typedef struct {
        int           which;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset       [3];
    logic         in_valid    [3];
    logic         in_ready    [3];
    logic [127:0] cipher_data [3];
    logic         iv_load     [3];
    logic [127:0] iv          [3];
    logic [3:0]   rk_idx      [3];
    logic [127:0] rk_data     [3];
    logic         out_valid   [3];
    logic         out_ready   [3];
    logic [127:0] plain_data  [3];
    logic         busy        [3];

    logic [127:0] rks [3][16];
    exp_t         exp_q [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes_decrypt_iter #(.NR(10), .CBC(0)) u_ecb128 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .cipher_data(cipher_data[0]), .iv_load(iv_load[0]), .iv(iv[0]),
        .rk_idx(rk_idx[0]), .rk_data(rk_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .plain_data(plain_data[0]), .busy(busy[0]));

    aes_decrypt_iter #(.NR(14), .CBC(0)) u_ecb256 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .cipher_data(cipher_data[1]), .iv_load(iv_load[1]), .iv(iv[1]),
        .rk_idx(rk_idx[1]), .rk_data(rk_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .plain_data(plain_data[1]), .busy(busy[1]));

    aes_decrypt_iter #(.NR(10), .CBC(1)) u_cbc128 (
        .clk(clk), .reset(reset[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .cipher_data(cipher_data[2]), .iv_load(iv_load[2]), .iv(iv[2]),
        .rk_idx(rk_idx[2]), .rk_data(rk_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .plain_data(plain_data[2]), .busy(busy[2]));

    assign rk_data[0] = rks[0][rk_idx[0]];
    assign rk_data[1] = rks[1][rk_idx[1]];
    assign rk_data[2] = rks[2][rk_idx[2]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
    endfunction

    // Standard AES key expansion; key is left-aligned in 256 bits.
    task automatic expand(input int which, input logic [255:0] key, input int nk);
        logic [31:0] wd [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wd[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int k = 0; k < 16; k++) rks[which][k] = '0;
        for (int k = 0; k <= nr; k++) rks[which][k] = {wd[4*k], wd[4*k+1], wd[4*k+2], wd[4*k+3]};
    endtask

    // Output monitor: one comparison per plaintext handshake.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output dut%0d: got %h expected none", i, plain_data[i]);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dut", 128'(i), 128'(e.which));
                    check("sb_plain", plain_data[i], e.data);
                end
            end
        end
    end

    // Issue one block and follow it through to the return to IDLE.
    task automatic send(input int w, input logic [127:0] ct, input logic [127:0] pt,
                        input int hold, input bit iv_now, input logic [127:0] iv_val,
                        input bit iv_mid);
        int   nr;
        int   n;
        exp_t e;
        nr = (w == 1) ? 14 : 10;
        out_ready[w]   = (hold == 0);
        cipher_data[w] = ct;
        in_valid[w]    = 1'b1;
        iv_load[w]     = iv_now;
        iv[w]          = iv_val;
        check("idle_in_ready", 128'(in_ready[w]), 128'(1));
        check("idle_rk_idx", 128'(rk_idx[w]), 128'(nr));
        e.which = w;
        e.data  = pt;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid[w]    = 1'b0;
        iv_load[w]     = 1'b0;
        cipher_data[w] = {$urandom, $urandom, $urandom, $urandom};
        iv[w]          = {$urandom, $urandom, $urandom, $urandom};
        check("run_busy", 128'(busy[w]), 128'(1));
        check("run_in_ready", 128'(in_ready[w]), 128'(0));
        n = 0;
        while (out_valid[w] !== 1'b1 && n < 40) begin
            check("rk_idx_seq", 128'(rk_idx[w]), 128'((n < nr - 1) ? nr - 1 - n : 0));
            if (iv_mid) iv_load[w] = (n == 3);
            @(posedge clk); #1;
            n++;
        end
        iv_load[w] = 1'b0;
        check("latency", 128'(n), 128'(nr));
        check("done_rk_idx", 128'(rk_idx[w]), 128'(0));
        for (int i = 0; i < hold; i++) begin
            check("hold_plain", plain_data[w], pt);
            check("hold_valid", 128'(out_valid[w]), 128'(1));
            check("hold_in_ready", 128'(in_ready[w]), 128'(0));
            in_valid[w]    = 1'b1;
            cipher_data[w] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid[w]  = 1'b0;
        out_ready[w] = 1'b1;
        @(posedge clk); #1;
        check("back_idle_ready", 128'(in_ready[w]), 128'(1));
        check("back_idle_valid", 128'(out_valid[w]), 128'(0));
        check("back_idle_busy", 128'(busy[w]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            reset[i]       = 1'b1;
            in_valid[i]    = 1'b0;
            cipher_data[i] = '0;
            iv_load[i]     = 1'b0;
            iv[i]          = '0;
            out_ready[i]   = 1'b1;
        end
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        expand(2, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 128'(in_ready[i]), 128'(1));
            check("rst_busy", 128'(busy[i]), 128'(0));
            check("rst_out_valid", 128'(out_valid[i]), 128'(0));
            check("rst_plain", plain_data[i], 128'h0);
            check("rst_rk_idx", 128'(rk_idx[i]), 128'((i == 1) ? 14 : 10));
        end

        // AES-128 ECB, then the same block under 5 cycles of backpressure
        // with a junk iv_load on the accept edge (no effect in ECB).
        send(0, CT_128, PT_FIPS, 0, 1'b0, '0, 1'b0);
        send(0, CT_128, PT_FIPS, 5, 1'b1, 128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b0);

        // Reset wins over in_valid on the same edge.
        reset[0]       = 1'b1;
        in_valid[0]    = 1'b1;
        cipher_data[0] = CT_128;
        @(posedge clk); #1;
        reset[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("rst_prio_busy", 128'(busy[0]), 128'(0));
        check("rst_prio_in_ready", 128'(in_ready[0]), 128'(1));

        // AES-256 ECB
        send(1, CT_256, PT_FIPS, 0, 1'b0, '0, 1'b0);

        // AES-128 CBC: IV load in idle, then two chained blocks.
        iv_load[2] = 1'b1;
        iv[2]      = CBC_IV;
        @(posedge clk); #1;
        iv_load[2] = 1'b0;
        iv[2]      = '0;
        send(2, CBC_C1, CBC_P1, 0, 1'b0, '0, 1'b0);
        send(2, CBC_C2, CBC_P2, 0, 1'b0, '0, 1'b0);
        // IV load on the accept edge applies to that block.
        send(2, CBC_C1, CBC_P1, 0, 1'b1, CBC_IV, 1'b0);
        // IV load during rounds is ignored: chain stays C1.
        send(2, CBC_C2, CBC_P2, 0, 1'b0, '0, 1'b1);

        // Abort with reset at r=5: no output, chain cleared.
        cipher_data[2] = CBC_C1;
        in_valid[2]    = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        n = 0;
        while (rk_idx[2] !== 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_at_r5", 128'(rk_idx[2]), 128'(5));
        reset[2]    = 1'b1;
        in_valid[2] = 1'b1;
        iv_load[2]  = 1'b1;
        iv[2]       = CBC_IV;
        @(posedge clk); #1;
        reset[2]    = 1'b0;
        in_valid[2] = 1'b0;
        iv_load[2]  = 1'b0;
        check("abort_out_valid", 128'(out_valid[2]), 128'(0));
        check("abort_busy", 128'(busy[2]), 128'(0));
        check("abort_in_ready", 128'(in_ready[2]), 128'(1));
        check("abort_rk_idx", 128'(rk_idx[2]), 128'(10));
        // With chain = 0 the output is the raw decryption, P2 ^ C1.
        send(2, CBC_C2, CBC_P2 ^ CBC_C1, 0, 1'b0, '0, 1'b0);
        send(2, CBC_C1, CBC_P1, 0, 1'b1, CBC_IV, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
